// File: rtl/d_cache_axi_mem_responder_if.sv
// AXI-lite bus between the D-cache master port and its memory responder.
// Write channel carries one word; the read channel returns a whole D_WORD-word line.
interface d_cache_axi_mem_responder_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned D_WORD = 4
);
    logic                   D_Cache_AXI_AWVALID;
    logic                   D_Cache_AXI_AWREADY;
    logic [XLEN-1:0]        D_Cache_AXI_AWADDR;
    logic [2:0]             D_Cache_AXI_AWPROT;
    logic [3:0]             D_Cache_AXI_AWCACHE;
    logic                   D_Cache_AXI_WVALID;
    logic                   D_Cache_AXI_WREADY;
    logic [XLEN-1:0]        D_Cache_AXI_WDATA;
    logic [3:0]             D_Cache_AXI_WSTRB;
    logic                   D_Cache_AXI_BVALID;
    logic                   D_Cache_AXI_BREADY;
    logic [1:0]             D_Cache_AXI_BRESP;
    logic                   D_Cache_AXI_ARVALID;
    logic                   D_Cache_AXI_ARREADY;
    logic [XLEN-1:0]        D_Cache_AXI_ARADDR;
    logic [2:0]             D_Cache_AXI_ARPROT;
    logic [3:0]             D_Cache_AXI_ARCACHE;
    logic                   D_Cache_AXI_RVALID;
    logic                   D_Cache_AXI_RREADY;
    logic [XLEN*D_WORD-1:0] D_Cache_AXI_RDATA;
    logic [1:0]             D_Cache_AXI_RRESP;

    modport master (
        output D_Cache_AXI_AWVALID, D_Cache_AXI_AWADDR, D_Cache_AXI_AWPROT, D_Cache_AXI_AWCACHE,
        input  D_Cache_AXI_AWREADY,
        output D_Cache_AXI_WVALID, D_Cache_AXI_WDATA, D_Cache_AXI_WSTRB,
        input  D_Cache_AXI_WREADY,
        input  D_Cache_AXI_BVALID, D_Cache_AXI_BRESP,
        output D_Cache_AXI_BREADY,
        output D_Cache_AXI_ARVALID, D_Cache_AXI_ARADDR, D_Cache_AXI_ARPROT, D_Cache_AXI_ARCACHE,
        input  D_Cache_AXI_ARREADY,
        input  D_Cache_AXI_RVALID, D_Cache_AXI_RDATA, D_Cache_AXI_RRESP,
        output D_Cache_AXI_RREADY
    );

    modport slave (
        input  D_Cache_AXI_AWVALID, D_Cache_AXI_AWADDR, D_Cache_AXI_AWPROT, D_Cache_AXI_AWCACHE,
        output D_Cache_AXI_AWREADY,
        input  D_Cache_AXI_WVALID, D_Cache_AXI_WDATA, D_Cache_AXI_WSTRB,
        output D_Cache_AXI_WREADY,
        output D_Cache_AXI_BVALID, D_Cache_AXI_BRESP,
        input  D_Cache_AXI_BREADY,
        input  D_Cache_AXI_ARVALID, D_Cache_AXI_ARADDR, D_Cache_AXI_ARPROT, D_Cache_AXI_ARCACHE,
        output D_Cache_AXI_ARREADY,
        output D_Cache_AXI_RVALID, D_Cache_AXI_RDATA, D_Cache_AXI_RRESP,
        input  D_Cache_AXI_RREADY
    );
endinterface

// File: rtl/d_cache_axi_mem_responder.sv
// AXI-lite data memory behind the D-cache: byte-strobed single-word writes,
// fixed-latency line reads, independent read and write FSMs over one word array.
module d_cache_axi_mem_responder #(
    parameter int unsigned     XLEN         = 32,
    parameter int unsigned     D_WORD       = 4,
    parameter int unsigned     DEPTH        = 256,
    parameter logic [XLEN-1:0] BASE_ADDR    = '0,
    parameter int unsigned     READ_LATENCY = 2,
    parameter string           INIT_FILE    = ""
) (
    input  logic                          CLK,
    input  logic                          rst_n,
    d_cache_axi_mem_responder_if.slave    bus
);
    localparam int WA = $clog2(DEPTH);
    localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    localparam logic [1:0] W_IDLE    = 2'd0;
    localparam logic [1:0] W_NEED_W  = 2'd1;
    localparam logic [1:0] W_NEED_AW = 2'd2;
    localparam logic [1:0] W_RESP    = 2'd3;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_WAIT = 2'd1;
    localparam logic [1:0] R_RESP = 2'd2;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    function automatic logic in_range(input logic [XLEN-1:0] a);
        logic [XLEN:0] lim;
        lim = {1'b0, BASE_ADDR} + (XLEN+1)'(4 * DEPTH);
        return (a >= BASE_ADDR) && ({1'b0, a} < lim);
    endfunction

    function automatic logic [WA-1:0] word_idx(input logic [XLEN-1:0] a);
        logic [XLEN-1:0] off;
        off = a - BASE_ADDR;
        return WA'(off >> 2);
    endfunction

    function automatic logic [XLEN-1:0] merge_bytes(input logic [XLEN-1:0] old_w,
                                                    input logic [XLEN-1:0] new_w,
                                                    input logic [3:0]      strb);
        logic [XLEN-1:0] r;
        r = old_w;
        for (int i = 0; i < XLEN/8; i++)
            if (strb[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

    logic [XLEN-1:0]        mem [DEPTH];

    logic [1:0]             w_state;
    logic                   awready_q, wready_q, bvalid_q;
    logic [1:0]             bresp_q;
    logic [XLEN-1:0]        aw_addr_q, w_data_q;
    logic [3:0]             w_strb_q;

    logic [1:0]             r_state;
    logic                   arready_q, rvalid_q, r_ok_q;
    logic [1:0]             rresp_q;
    logic [XLEN*D_WORD-1:0] rdata_q;
    logic [CW-1:0]          cnt_q;
    logic [WA-1:0]          line_q;

    logic                   aw_hs, w_hs, ar_hs, commit, c_ok;
    logic [XLEN-1:0]        c_addr, c_data;
    logic [3:0]             c_strb;
    logic [WA-1:0]          c_word;

    assign aw_hs = bus.D_Cache_AXI_AWVALID & awready_q;
    assign w_hs  = bus.D_Cache_AXI_WVALID  & wready_q;
    assign ar_hs = bus.D_Cache_AXI_ARVALID & arready_q;

    // The write commits on the edge that completes the second of the AW/W handshakes.
    always_comb begin
        commit = 1'b0;
        c_addr = bus.D_Cache_AXI_AWADDR;
        c_data = bus.D_Cache_AXI_WDATA;
        c_strb = bus.D_Cache_AXI_WSTRB;
        case (w_state)
            W_IDLE:    commit = aw_hs & w_hs;
            W_NEED_W:  begin commit = w_hs;  c_addr = aw_addr_q; end
            W_NEED_AW: begin commit = aw_hs; c_data = w_data_q; c_strb = w_strb_q; end
            default:   commit = 1'b0;
        endcase
        c_ok   = in_range(c_addr);
        c_word = word_idx(c_addr);
    end

    always_ff @(posedge CLK) begin
        if (commit && c_ok) mem[c_word] <= merge_bytes(mem[c_word], c_data, c_strb);
        if (aw_hs) aw_addr_q <= bus.D_Cache_AXI_AWADDR;
        if (w_hs) begin
            w_data_q <= bus.D_Cache_AXI_WDATA;
            w_strb_q <= bus.D_Cache_AXI_WSTRB;
        end
        if (ar_hs) line_q <= word_idx(bus.D_Cache_AXI_ARADDR) & ~WA'(D_WORD - 1);
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            w_state   <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
        end else if (commit) begin
            w_state   <= W_RESP;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= c_ok ? OKAY : SLVERR;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        w_state   <= W_NEED_W;
                        awready_q <= 1'b0;
                    end else if (w_hs) begin
                        w_state  <= W_NEED_AW;
                        wready_q <= 1'b0;
                    end else begin
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
                W_RESP: begin
                    if (bus.D_Cache_AXI_BREADY) begin
                        w_state   <= W_IDLE;
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sampling in R_WAIT sees the array before any same-edge commit (read-before-write).
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= OKAY;
            rdata_q   <= '0;
            cnt_q     <= '0;
            r_ok_q    <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        r_state   <= R_WAIT;
                        arready_q <= 1'b0;
                        cnt_q     <= CW'(READ_LATENCY - 1);
                        r_ok_q    <= in_range(bus.D_Cache_AXI_ARADDR);
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        for (int k = 0; k < D_WORD; k++)
                            rdata_q[XLEN*k +: XLEN] <= r_ok_q ? mem[line_q + WA'(k)] : '0;
                        rresp_q  <= r_ok_q ? OKAY : SLVERR;
                        rvalid_q <= 1'b1;
                        r_state  <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (bus.D_Cache_AXI_RREADY) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        r_state   <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    logic unused_ok;
    assign unused_ok = ^{bus.D_Cache_AXI_AWPROT, bus.D_Cache_AXI_AWCACHE,
                         bus.D_Cache_AXI_ARPROT, bus.D_Cache_AXI_ARCACHE};

    assign bus.D_Cache_AXI_AWREADY = awready_q;
    assign bus.D_Cache_AXI_WREADY  = wready_q;
    assign bus.D_Cache_AXI_BVALID  = bvalid_q;
    assign bus.D_Cache_AXI_BRESP   = bresp_q;
    assign bus.D_Cache_AXI_ARREADY = arready_q;
    assign bus.D_Cache_AXI_RVALID  = rvalid_q;
    assign bus.D_Cache_AXI_RDATA   = rdata_q;
    assign bus.D_Cache_AXI_RRESP   = rresp_q;
endmodule

// File: tb/tb_d_cache_axi_mem_responder.sv
// Bench for d_cache_axi_mem_responder: directed scenarios plus random traffic
// checked against a word-array reference model of the memory.
module tb_d_cache_axi_mem_responder;
    localparam int XLEN   = 32;
    localparam int D_WORD = 4;
    localparam int DEPTH  = 256;
    localparam int RLAT   = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    d_cache_axi_mem_responder_if #(.XLEN(XLEN), .D_WORD(D_WORD)) bus ();

    d_cache_axi_mem_responder #(
        .XLEN(XLEN), .D_WORD(D_WORD), .DEPTH(DEPTH),
        .BASE_ADDR('0), .READ_LATENCY(RLAT), .INIT_FILE("")
    ) dut (
        .CLK(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] model [DEPTH];

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic bit addr_ok(input logic [31:0] a);
        return a < 32'(4 * DEPTH);
    endfunction

    function automatic logic [127:0] model_line(input logic [31:0] a);
        logic [127:0] l;
        int base;
        l = '0;
        if (addr_ok(a)) begin
            base = int'(a / 4) / D_WORD * D_WORD;
            for (int k = 0; k < D_WORD; k++) l[32*k +: 32] = model[base + k];
        end
        return l;
    endfunction

    // All tasks start and end 1 time unit after a rising edge.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_d, input int w_d, input int hold);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        int cyc = 0;
        logic [1:0] exp_resp;
        while (!(aw_done && w_done) && cyc < 40) begin
            bus.D_Cache_AXI_AWVALID = !aw_done && cyc >= aw_d;
            bus.D_Cache_AXI_AWADDR  = a;
            bus.D_Cache_AXI_AWPROT  = 3'($urandom);
            bus.D_Cache_AXI_AWCACHE = 4'($urandom);
            bus.D_Cache_AXI_WVALID  = !w_done && cyc >= w_d;
            bus.D_Cache_AXI_WDATA   = d;
            bus.D_Cache_AXI_WSTRB   = s;
            aw_hs = bus.D_Cache_AXI_AWVALID && bus.D_Cache_AXI_AWREADY;
            w_hs  = bus.D_Cache_AXI_WVALID && bus.D_Cache_AXI_WREADY;
            @(posedge clk); #1;
            cyc++;
            if (aw_hs) aw_done = 1;
            if (w_hs)  w_done = 1;
            if (w_done && !aw_done)  chk("wready_wait_aw", bus.D_Cache_AXI_WREADY, 0);
            if (aw_done && !w_done)  chk("awready_wait_w", bus.D_Cache_AXI_AWREADY, 0);
            if (!(aw_done && w_done)) chk("bvalid_early", bus.D_Cache_AXI_BVALID, 0);
        end
        bus.D_Cache_AXI_AWVALID = 0;
        bus.D_Cache_AXI_WVALID  = 0;
        if (!(aw_done && w_done)) begin
            chk("wr_handshake_timeout", 0, 1);
            return;
        end
        exp_resp = addr_ok(a) ? 2'b00 : 2'b10;
        if (addr_ok(a))
            for (int i = 0; i < 4; i++)
                if (s[i]) model[a / 4][8*i +: 8] = d[8*i +: 8];
        chk("bvalid", bus.D_Cache_AXI_BVALID, 1);
        chk("bresp", bus.D_Cache_AXI_BRESP, exp_resp);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("bvalid_hold", bus.D_Cache_AXI_BVALID, 1);
            chk("bresp_hold", bus.D_Cache_AXI_BRESP, exp_resp);
            chk("awready_hold", bus.D_Cache_AXI_AWREADY, 0);
        end
        bus.D_Cache_AXI_BREADY = 1;
        @(posedge clk); #1;
        bus.D_Cache_AXI_BREADY = 0;
        chk("bvalid_drop", bus.D_Cache_AXI_BVALID, 0);
        chk("awready_back", bus.D_Cache_AXI_AWREADY, 1);
    endtask

    task automatic ar_handshake(input logic [31:0] a, output bit ok);
        bit hs = 0;
        int cyc = 0;
        bus.D_Cache_AXI_ARVALID = 1;
        bus.D_Cache_AXI_ARADDR  = a;
        bus.D_Cache_AXI_ARPROT  = 3'($urandom);
        bus.D_Cache_AXI_ARCACHE = 4'($urandom);
        while (!hs && cyc < 20) begin
            hs = bus.D_Cache_AXI_ARREADY;
            @(posedge clk); #1;
            cyc++;
        end
        bus.D_Cache_AXI_ARVALID = 0;
        ok = hs;
        if (!hs) chk("ar_handshake_timeout", 0, 1);
    endtask

    task automatic do_read(input logic [31:0] a, input int hold);
        bit ok;
        int lat = 0;
        logic [127:0] exp_line;
        logic [1:0]   exp_resp;
        ar_handshake(a, ok);
        if (!ok) return;
        chk("arready_after_ar", bus.D_Cache_AXI_ARREADY, 0);
        while (!bus.D_Cache_AXI_RVALID && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("rd_latency", lat, RLAT);
        exp_line = model_line(a);
        exp_resp = addr_ok(a) ? 2'b00 : 2'b10;
        chk("rdata", bus.D_Cache_AXI_RDATA, exp_line);
        chk("rresp", bus.D_Cache_AXI_RRESP, exp_resp);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("rvalid_hold", bus.D_Cache_AXI_RVALID, 1);
            chk("rdata_hold", bus.D_Cache_AXI_RDATA, exp_line);
            chk("arready_hold", bus.D_Cache_AXI_ARREADY, 0);
        end
        bus.D_Cache_AXI_RREADY = 1;
        @(posedge clk); #1;
        bus.D_Cache_AXI_RREADY = 0;
        chk("rvalid_drop", bus.D_Cache_AXI_RVALID, 0);
        chk("arready_back", bus.D_Cache_AXI_ARREADY, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        logic [31:0] a;
        bus.D_Cache_AXI_AWVALID = 0; bus.D_Cache_AXI_AWADDR = '0;
        bus.D_Cache_AXI_AWPROT  = '0; bus.D_Cache_AXI_AWCACHE = '0;
        bus.D_Cache_AXI_WVALID  = 0; bus.D_Cache_AXI_WDATA = '0; bus.D_Cache_AXI_WSTRB = '0;
        bus.D_Cache_AXI_BREADY  = 0;
        bus.D_Cache_AXI_ARVALID = 0; bus.D_Cache_AXI_ARADDR = '0;
        bus.D_Cache_AXI_ARPROT  = '0; bus.D_Cache_AXI_ARCACHE = '0;
        bus.D_Cache_AXI_RREADY  = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", bus.D_Cache_AXI_AWREADY, 0);
        chk("rst_wready", bus.D_Cache_AXI_WREADY, 0);
        chk("rst_arready", bus.D_Cache_AXI_ARREADY, 0);
        chk("rst_bvalid", bus.D_Cache_AXI_BVALID, 0);
        chk("rst_rvalid", bus.D_Cache_AXI_RVALID, 0);
        chk("rst_rdata", bus.D_Cache_AXI_RDATA, 0);
        @(negedge clk);
        rst_n = 1;
        #1;
        chk("rel_awready_low", bus.D_Cache_AXI_AWREADY, 0);
        chk("rel_arready_low", bus.D_Cache_AXI_ARREADY, 0);
        @(posedge clk); #1;
        chk("rel_awready_high", bus.D_Cache_AXI_AWREADY, 1);
        chk("rel_wready_high", bus.D_Cache_AXI_WREADY, 1);
        chk("rel_arready_high", bus.D_Cache_AXI_ARREADY, 1);

        // Give every word a known value so line reads are fully predictable.
        for (int w = 0; w < DEPTH; w++) do_write(32'(4 * w), $urandom, 4'hF, 0, 0, 0);

        do_write(32'h10, 32'h11223344, 4'hF, 0, 0, 0);
        do_read(32'h10, 0);
        chk("t1_word", bus.D_Cache_AXI_RDATA[31:0], 32'h11223344);
        do_write(32'h10, 32'hAABBCCDD, 4'b0010, 0, 0, 0);
        do_read(32'h10, 0);
        chk("t2_merge", model[4], 32'h1122CC44);
        do_write(32'h20, 32'hCAFEF00D, 4'hF, 3, 0, 0);
        do_read(32'h20, 0);
        do_write(32'h34, 32'h5A5A0101, 4'hF, 0, 2, 0);
        do_read(32'h37, 0);
        do_write(32'h1000, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        do_read(32'h1000, 0);
        do_read(32'h0, 0);
        do_read(32'h3FC, 0);
        do_write(32'h44, 32'h01020304, 4'b1001, 1, 1, 5);
        do_read(32'h44, 5);

        ar_handshake(32'h10, ok);
        @(negedge clk);
        rst_n = 0;
        #1;
        chk("rst_mid_rvalid", bus.D_Cache_AXI_RVALID, 0);
        chk("rst_mid_arready", bus.D_Cache_AXI_ARREADY, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        #1;
        chk("rst_mid_rel_arready", bus.D_Cache_AXI_ARREADY, 0);
        @(posedge clk); #1;
        do_read(32'h10, 0);

        for (int i = 0; i < 80; i++) begin
            a = $urandom_range(0, 32'h4FF);
            if ($urandom_range(0, 1) == 1)
                do_write({a[31:2], 2'b00} | 32'($urandom_range(0, 3)), $urandom, 4'($urandom),
                         $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            else
                do_read(a, $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
